// File: rtl/instr_aligner.sv
// rtl/instr_aligner.sv - halfword realignment buffer between word fetch and instruction decode
module instr_aligner #(
  parameter int          DEPTH    = 8,
  parameter int          C_EXT    = 1,
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_flush,
  input  logic [31:0] I_flush_pc,
  input  logic        I_fetch_valid,
  input  logic [31:0] I_fetch_data,
  output logic        O_fetch_ready,
  output logic        O_valid,
  input  logic        I_ready,
  output logic [31:0] O_instr,
  output logic [31:0] O_pc,
  output logic        O_compressed,
  output logic        O_illegal
);

  localparam int          AW          = $clog2(DEPTH);
  localparam bit          CX          = (C_EXT != 0);
  localparam int unsigned READY_MAX_I = DEPTH - 2;
  localparam logic [AW:0] READY_MAX   = READY_MAX_I[AW:0];
  localparam logic [AW:0] ONE         = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] TWO         = {{(AW-1){1'b0}}, 2'b10};

  logic [15:0] slot [DEPTH];
  logic [AW:0] head, tail, count;
  logic [AW:0] head_p1, tail_p1;
  logic [AW:0] push_amt, pop_amt;
  logic        discard_low;
  logic [31:0] pc;
  logic [15:0] h0, h1;
  logic        is_comp, low_not_32;
  logic        push, pop;
  logic        unused_flush_pc_lsb;

  assign unused_flush_pc_lsb = I_flush_pc[0];

  // Pointers carry one extra wrap bit so a full buffer differs from an empty one.
  assign count   = tail - head;
  assign head_p1 = head + ONE;
  assign tail_p1 = tail + ONE;

  assign h0         = slot[head[AW-1:0]];
  assign h1         = slot[head_p1[AW-1:0]];
  assign low_not_32 = (h0[1:0] != 2'b11);
  assign is_comp    = CX && low_not_32;

  assign O_fetch_ready = (count <= READY_MAX);
  assign O_valid       = is_comp ? (count >= ONE) : (count >= TWO);
  assign O_instr       = is_comp ? {16'h0000, h0} : {h1, h0};
  assign O_pc          = pc;
  assign O_compressed  = is_comp;
  assign O_illegal     = !CX && O_valid && low_not_32;

  assign push     = I_fetch_valid && O_fetch_ready && !I_flush;
  assign pop      = O_valid && I_ready && !I_flush;
  assign push_amt = discard_low ? ONE : TWO;
  assign pop_amt  = is_comp ? ONE : TWO;

  // Slot contents need no reset: the pointers alone decide what is live.
  always_ff @(posedge I_clk) begin
    if (push) begin
      if (discard_low) begin
        slot[tail[AW-1:0]] <= I_fetch_data[31:16];
      end else begin
        slot[tail[AW-1:0]]    <= I_fetch_data[15:0];
        slot[tail_p1[AW-1:0]] <= I_fetch_data[31:16];
      end
    end
  end

  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      head        <= '0;
      tail        <= '0;
      discard_low <= 1'b0;
      pc          <= PC_RESET;
    end else if (I_flush) begin
      head        <= '0;
      tail        <= '0;
      discard_low <= CX && I_flush_pc[1];
      // Without compressed support every target is word aligned.
      pc          <= CX ? {I_flush_pc[31:1], 1'b0} : {I_flush_pc[31:2], 2'b00};
    end else begin
      if (push) begin
        tail        <= tail + push_amt;
        discard_low <= 1'b0;
      end
      if (pop) begin
        head <= head + pop_amt;
        pc   <= pc + (is_comp ? 32'd2 : 32'd4);
      end
    end
  end

endmodule

// File: tb/tb_instr_aligner.sv
// tb/tb_instr_aligner.sv - vector table, directed sequences and random model checks for instr_aligner
module tb_instr_aligner;

  localparam int          DEPTH   = 8;
  localparam logic [31:0] PC_RST0 = 32'h8000_0000;
  localparam logic [31:0] ADDI    = 32'h0010_0093;

  logic        clk = 1'b0;
  logic        rst, flush, fv, rdy;
  logic [31:0] flush_pc, fd;

  logic        a_fready, a_valid, a_comp, a_ill;
  logic [31:0] a_instr, a_pc;
  logic        b_fready, b_valid, b_comp, b_ill;
  logic [31:0] b_instr, b_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_aligner #(.DEPTH(DEPTH), .C_EXT(1), .PC_RESET(32'h0)) u_dut (
    .I_clk(clk), .I_reset(rst), .I_flush(flush), .I_flush_pc(flush_pc),
    .I_fetch_valid(fv), .I_fetch_data(fd), .O_fetch_ready(a_fready),
    .O_valid(a_valid), .I_ready(rdy), .O_instr(a_instr), .O_pc(a_pc),
    .O_compressed(a_comp), .O_illegal(a_ill)
  );

  instr_aligner #(.DEPTH(DEPTH), .C_EXT(0), .PC_RESET(PC_RST0)) u_dut_nc (
    .I_clk(clk), .I_reset(rst), .I_flush(flush), .I_flush_pc(flush_pc),
    .I_fetch_valid(fv), .I_fetch_data(fd), .O_fetch_ready(b_fready),
    .O_valid(b_valid), .I_ready(rdy), .O_instr(b_instr), .O_pc(b_pc),
    .O_compressed(b_comp), .O_illegal(b_ill)
  );

  typedef struct {
    bit          sel0;
    bit          fl;
    logic [31:0] fpc;
    bit          fv;
    logic [31:0] fd;
    bit          rdy;
    bit          ev;
    logic [31:0] ei;
    logic [31:0] epc;
    bit          ec;
    bit          ef;
    bit          eill;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit sel0, bit fl, logic [31:0] fpc, bit fvi, logic [31:0] fdi,
                              bit rdyi, bit ev, logic [31:0] ei, logic [31:0] epc,
                              bit ec, bit ef, bit eill);
    vec_t r;
    r.sel0 = sel0; r.fl = fl; r.fpc = fpc; r.fv = fvi; r.fd = fdi; r.rdy = rdyi;
    r.ev = ev; r.ei = ei; r.epc = epc; r.ec = ec; r.ef = ef; r.eill = eill;
    return r;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    flush = 1'b0; fv = 1'b0; rdy = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic run_row(input int idx, input vec_t r);
    logic        v, f, c, il;
    logic [31:0] ins, p;
    flush = r.fl; flush_pc = r.fpc; fv = r.fv; fd = r.fd; rdy = r.rdy;
    #3;
    if (r.sel0) begin
      v = b_valid; f = b_fready; c = b_comp; il = b_ill; ins = b_instr; p = b_pc;
    end else begin
      v = a_valid; f = a_fready; c = a_comp; il = a_ill; ins = a_instr; p = a_pc;
    end
    chk1($sformatf("row%0d valid", idx), v, r.ev);
    chk1($sformatf("row%0d fetch_ready", idx), f, r.ef);
    chk1($sformatf("row%0d illegal", idx), il, r.eill);
    if (r.ev) begin
      chk32($sformatf("row%0d instr", idx), ins, r.ei);
      chk32($sformatf("row%0d pc", idx), p, r.epc);
      chk1($sformatf("row%0d compressed", idx), c, r.ec);
    end
    tick();
  endtask

  logic [15:0] hq[$];
  logic [31:0] mpc;
  bit          mdisc;
  bit          m_comp, m_valid, m_fr;
  logic [31:0] m_instr;

  initial begin
    rst = 1'b1; flush = 1'b0; flush_pc = '0; fv = 1'b0; fd = '0; rdy = 1'b0;

    // Four ADDI words streamed back to back
    tbl.push_back(mk(0,0,0,1,ADDI,1, 0,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,1,ADDI,1, 1,ADDI,0,0,1,0));
    tbl.push_back(mk(0,0,0,1,ADDI,1, 1,ADDI,4,0,1,0));
    tbl.push_back(mk(0,0,0,1,ADDI,1, 1,ADDI,8,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,1,    1,ADDI,12,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,1,    0,0,0,0,1,0));
    // Two C.NOP then a 32-bit NOP
    tbl.push_back(mk(0,1,0,1,32'hDEADBEEF,1, 0,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,1,32'h00010001,1, 0,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,1,32'h00000013,1, 1,32'h1,0,1,1,0));
    tbl.push_back(mk(0,0,0,0,0,1,            1,32'h1,2,1,1,0));
    tbl.push_back(mk(0,0,0,0,0,1,            1,32'h13,4,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,1,            0,0,0,0,1,0));
    // Straddling 32-bit instruction
    tbl.push_back(mk(0,1,0,0,0,1,            0,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,1,32'h00930001,1, 0,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,1,            1,32'h1,0,1,1,0));
    tbl.push_back(mk(0,0,0,1,32'h00000010,1, 0,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,1,            1,ADDI,2,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,            1,32'h0,6,1,1,0));
    // Flush to a halfword-aligned target
    tbl.push_back(mk(0,1,32'h102,1,32'h12345678,1, 1,32'h0,6,1,1,0));
    tbl.push_back(mk(0,0,0,1,32'h4505ABCD,1,       0,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,0,                  1,32'h4505,32'h102,1,1,0));
    tbl.push_back(mk(0,0,0,0,0,1,                  1,32'h4505,32'h102,1,1,0));
    tbl.push_back(mk(0,0,0,0,0,1,                  0,0,0,0,1,0));
    // Fill to capacity, then drain across the pointer wrap
    tbl.push_back(mk(0,1,0,0,0,0,            0,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,1,32'h10032003,0, 0,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,1,32'h30034003,0, 1,32'h10032003,0,0,1,0));
    tbl.push_back(mk(0,0,0,1,32'h50036003,0, 1,32'h10032003,0,0,1,0));
    tbl.push_back(mk(0,0,0,1,32'h70038003,0, 1,32'h10032003,0,0,1,0));
    tbl.push_back(mk(0,0,0,1,32'h9003A003,0, 1,32'h10032003,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,32'h9003A003,1, 1,32'h10032003,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,32'h9003A003,1, 1,32'h30034003,4,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,1,            1,32'h50036003,8,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,1,            1,32'h70038003,12,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,1,            1,32'h9003A003,16,0,1,0));
    tbl.push_back(mk(0,0,0,0,0,1,            0,0,0,0,1,0));
    // C_EXT=0 instance: bit 1 of the flush target is ignored, non-11 low bits are illegal
    tbl.push_back(mk(1,1,32'h102,1,32'hCAFEF00D,0, 0,0,0,0,1,0));
    tbl.push_back(mk(1,0,0,1,32'h00000001,0,       0,0,0,0,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,                  1,32'h1,32'h100,0,1,1));
    tbl.push_back(mk(1,0,0,0,0,1,                  1,32'h1,32'h100,0,1,1));
    tbl.push_back(mk(1,0,0,1,ADDI,0,               0,0,0,0,1,0));
    tbl.push_back(mk(1,0,0,0,0,0,                  1,ADDI,32'h104,0,1,0));

    tick();
    chk1("reset valid", a_valid, 1'b0);
    chk1("reset fetch_ready", a_fready, 1'b1);
    chk1("reset illegal nc", b_ill, 1'b0);
    chk32("reset pc", a_pc, 32'h0);
    chk32("reset pc nc", b_pc, PC_RST0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].sel0 && (i == 0 || !tbl[i-1].sel0)) pulse_reset();
      run_row(i, tbl[i]);
    end

    // Asynchronous reset while an instruction is presented
    flush = 1'b0; fv = 1'b0; rdy = 1'b0;
    #2;
    chk1("pre-reset valid nc", b_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk1("async reset valid nc", b_valid, 1'b0);
    chk32("async reset pc nc", b_pc, PC_RST0);
    chk1("async reset fetch_ready nc", b_fready, 1'b1);
    chk1("async reset illegal nc", b_ill, 1'b0);
    tick();
    rst = 1'b0;
    fv = 1'b1; fd = 32'h00000013;
    tick();
    fv = 1'b0;
    #3;
    chk1("post-reset valid nc", b_valid, 1'b1);
    chk32("post-reset pc nc", b_pc, PC_RST0);
    chk32("post-reset instr nc", b_instr, 32'h13);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    #3;
    chk1("post-pop valid nc", b_valid, 1'b0);
    chk32("post-pop pc nc", b_pc, PC_RST0 + 32'd4);
    tick();

    // Randomized traffic against a halfword-queue model
    pulse_reset();
    hq.delete(); mpc = 32'h0; mdisc = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      flush    = ($urandom_range(0, 99) < 3);
      flush_pc = $urandom;
      fv       = ($urandom_range(0, 99) < 70);
      fd       = $urandom;
      rdy      = ($urandom_range(0, 99) < 60);
      m_fr     = (hq.size() <= DEPTH - 2);
      m_comp   = 1'b0;
      if (hq.size() > 0) m_comp = (hq[0][1:0] != 2'b11);
      m_valid  = m_comp ? (hq.size() >= 1) : (hq.size() >= 2);
      #3;
      chk1("rnd fetch_ready", a_fready, m_fr);
      chk1("rnd valid", a_valid, m_valid);
      chk1("rnd illegal", a_ill, 1'b0);
      if (m_valid) begin
        m_instr = m_comp ? {16'h0, hq[0]} : {hq[1], hq[0]};
        chk32("rnd instr", a_instr, m_instr);
        chk32("rnd pc", a_pc, mpc);
        chk1("rnd compressed", a_comp, m_comp);
      end
      if (flush) begin
        hq.delete();
        mpc   = {flush_pc[31:1], 1'b0};
        mdisc = flush_pc[1];
      end else begin
        if (m_valid && rdy) begin
          void'(hq.pop_front());
          if (!m_comp) void'(hq.pop_front());
          mpc = mpc + (m_comp ? 32'd2 : 32'd4);
        end
        if (fv && m_fr) begin
          if (!mdisc) hq.push_back(fd[15:0]);
          hq.push_back(fd[31:16]);
          mdisc = 1'b0;
        end
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_aligner.md
INSTR_ALIGNER -- requirements
Module: instr_aligner

Interface
REQ-001 Parameter DEPTH, default 8: buffer capacity in halfword slots; power of two, >= 4.
REQ-002 Parameter C_EXT, default 1: 1 enables 16-bit compressed instructions; 0 means every instruction is 32 bits.
REQ-003 Parameter PC_RESET, default 32'h00000000: PC value after reset.
REQ-004 I_clk  in  1  the only clock; all state changes on its rising edge.
REQ-005 I_reset  in  1  asynchronous, active-high reset.
REQ-006 I_flush  in  1  discard all buffered halfwords and restart at I_flush_pc.
REQ-007 I_flush_pc  in  32  new PC; bit 0 ignored.
REQ-008 I_fetch_valid  in  1  I_fetch_data holds the next sequential word-aligned fetch word.
REQ-009 I_fetch_data  in  32  fetch word; bits 15:0 are the lower halfword.
REQ-010 O_fetch_ready  out  1  buffer can accept one word this cycle.
REQ-011 O_valid  out  1  O_instr holds a complete instruction.
REQ-012 I_ready  in  1  consumer takes O_instr this cycle.
REQ-013 O_instr  out  32  instruction; a compressed instruction sits zero-extended in bits 15:0.
REQ-014 O_pc  out  32  address of O_instr.
REQ-015 O_compressed  out  1  O_instr is a 16-bit instruction.
REQ-016 O_illegal  out  1  C_EXT=0 and O_instr[1:0] != 2'b11.

Function
REQ-017 Storage: circular buffer of DEPTH halfwords; head and tail pointers log2(DEPTH)+1 bits wide, so full and empty are distinguishable; count = tail - head.
REQ-018 O_fetch_ready = (count <= DEPTH-2); derived only from registered state, never from I_ready.
REQ-019 Push: I_fetch_valid & O_fetch_ready & !I_flush writes the lower halfword at tail, then the upper at tail+1; tail advances by 2.
REQ-020 Discard: if the discard_low flag is set, the push writes only the upper halfword, tail advances by 1, and discard_low clears.
REQ-021 Head halfword h0 = slot[head]; a compressed instruction is one where C_EXT=1 and h0[1:0] != 2'b11.
REQ-022 O_valid = (compressed & count >= 1) | (!compressed & count >= 2).
REQ-023 O_instr = compressed ? {16'h0, h0} : {slot[head+1], h0}; pointer arithmetic wraps modulo DEPTH.
REQ-024 Outputs are combinational from registered state; a word pushed in cycle N is visible at the outputs no earlier than cycle N+1.
REQ-025 Pop: O_valid & I_ready & !I_flush advances head by 1 (compressed) or 2 (not compressed); PC increments by 2 or 4, wrapping modulo 2^32.
REQ-026 Push and pop in the same cycle are both performed; count changes by the push amount minus the pop amount.
REQ-027 A 32-bit instruction whose halves straddle two fetch words is presented only once both halfwords are buffered.
REQ-028 I_flush has priority over push and pop. It sets head = tail = 0, PC = {I_flush_pc[31:1], 1'b0}, and discard_low = I_flush_pc[1] & C_EXT.
REQ-029 During a flush cycle fetch data is ignored; the cycle after a flush, O_valid=0.
REQ-030 C_EXT=0: O_compressed is always 0, discard_low never sets, and I_flush_pc[1] is treated as 0.
REQ-031 O_illegal = !C_EXT & O_valid & (h0[1:0] != 2'b11); the instruction is still consumed as 32 bits.
REQ-032 O_instr, O_pc and O_compressed may take any value while O_valid=0.

Reset
REQ-033 While I_reset=1, asynchronously and immediately: head=0, tail=0, discard_low=0, PC=PC_RESET; hence O_valid=0, O_fetch_ready=1, O_illegal=0.
REQ-034 Reset asserted mid-operation drops all buffered halfwords; after release, the first fetch word is treated as the word at PC_RESET.

Verification
REQ-035 Four fetch words of ADDI (0x00100093), I_ready=1 -> four instructions at PC 0, 4, 8, 12, one per cycle, O_compressed=0.
REQ-036 Word 0x00010001 (two C.NOP) then word 0x00000013 -> instructions 0x0001 @0 (compressed), 0x0001 @2 (compressed), 0x00000013 @4.
REQ-037 Straddle: word 0x00930001, then word 0x00000010 -> 0x0001 @0, then 0x00100093 @2 only after the second word is accepted.
REQ-038 I_flush with I_flush_pc=0x102, then word 0x4505ABCD -> the 0xABCD half is discarded; C.LI 0x4505 is presented at 0x102 with O_compressed=1.
REQ-039 With I_ready=0, push until O_fetch_ready=0 -> count = DEPTH (8 with DEPTH=8); a pop in the same cycle as a push is handled correctly across pointer wrap; no data loss or duplication.
REQ-040 C_EXT=0, word 0x00000001 -> O_valid=1, O_illegal=1, O_compressed=0; after the pop PC advances by 4. Assert I_reset mid-stream -> O_valid drops the same cycle and PC=PC_RESET.
